// File: rtl/adder_tpg_stream.sv
// adder_tpg_stream: bounded operand-pair generator for an adder under test.
// Emits PATTERNS (a, b) pairs over a valid/ready stream. The mode is latched
// on start. The LFSR, the step accumulators and the wrap counter advance
// only when a pattern is transferred.
module adder_tpg_stream #(
  parameter int               WIDTH    = 16,
  parameter int               PATTERNS = 128,
  parameter logic [WIDTH-1:0] SEED     = 16'h0001,
  parameter logic [WIDTH-1:0] TAPS     = 16'hE010,
  parameter int               A_STEP   = 511,
  parameter int               B_STEP   = 509,
  localparam int              IDXW     = $clog2(PATTERNS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             valid,
  input  logic             ready,
  output logic [IDXW-1:0]  pat_idx,
  output logic             busy,
  output logic             done
);

  localparam int WRW = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] A_STEP_W  = WIDTH'(A_STEP);
  localparam logic [WIDTH-1:0] B_STEP_W  = WIDTH'(B_STEP);
  localparam logic [IDXW-1:0]  IDX_ZERO  = {IDXW{1'b0}};
  localparam logic [IDXW-1:0]  IDX_ONE   = IDXW'(1);
  localparam logic [IDXW-1:0]  LAST_IDX  = IDXW'(PATTERNS - 1);
  localparam logic [WRW-1:0]   WR_ZERO   = {WRW{1'b0}};
  localparam logic [WRW-1:0]   WR_ONE    = WRW'(1);
  localparam logic [WRW-1:0]   LAST_WRAP = WRW'(WIDTH - 1);

  // Even parity of a word; used as the LFSR feedback bit.
  function automatic logic parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  // One Fibonacci LFSR step: shift left, feedback into bit 0.
  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] l);
    return {l[WIDTH-2:0], parity(l & TAPS)};
  endfunction

  // Build {a, b} for one pattern from the running index-derived state.
  function automatic logic [2*WIDTH-1:0] pattern(
    input logic [1:0]       m,
    input logic [WIDTH-1:0] l,
    input logic [WIDTH-1:0] acc_a,
    input logic [WIDTH-1:0] acc_b,
    input logic [WIDTH-1:0] cnt,
    input logic [WRW-1:0]   wrap
  );
    logic [WIDTH-1:0] pa;
    logic [WIDTH-1:0] pb;
    logic [WIDTH-1:0] onehot;
    onehot = ONE_W << wrap;
    case (m)
      2'd0: begin
        pa = (ALL_ONES - acc_a) ^ l;
        pb = (ONE_W + acc_b) ^ l;
      end
      2'd1: begin
        pa = onehot;
        pb = ~onehot;
      end
      2'd2: begin
        pa = cnt;
        pb = ~cnt;
      end
      2'd3: begin
        pa = ALL_ONES;
        pb = onehot;
      end
      default: begin
        pa = ZERO_W;
        pb = ZERO_W;
      end
    endcase
    return {pa, pb};
  endfunction

  logic [1:0]       state_r, state_s;
  logic [1:0]       mode_r, mode_s;
  logic [WIDTH-1:0] lfsr_r, lfsr_s;
  logic [WIDTH-1:0] acc_a_r, acc_a_s;
  logic [WIDTH-1:0] acc_b_r, acc_b_s;
  logic [WIDTH-1:0] cnt_r, cnt_s;
  logic [WRW-1:0]   wrap_r, wrap_s;
  logic [IDXW-1:0]  idx_r, idx_s;
  logic [WIDTH-1:0] a_r, a_s;
  logic [WIDTH-1:0] b_r, b_s;
  logic             valid_r, valid_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             xfer_s;

  logic [WIDTH-1:0] lfsr_adv_s;
  logic [WIDTH-1:0] acc_a_adv_s;
  logic [WIDTH-1:0] acc_b_adv_s;
  logic [WIDTH-1:0] cnt_adv_s;
  logic [WRW-1:0]   wrap_adv_s;

  assign xfer_s      = valid_r & ready;
  assign lfsr_adv_s  = lfsr_next(lfsr_r);
  assign acc_a_adv_s = acc_a_r + A_STEP_W;
  assign acc_b_adv_s = acc_b_r + B_STEP_W;
  assign cnt_adv_s   = cnt_r + ONE_W;
  assign wrap_adv_s  = (wrap_r == LAST_WRAP) ? WR_ZERO : (wrap_r + WR_ONE);

  // Next-state logic: accept start in IDLE/DONE, advance on transfer in RUN.
  always_comb begin
    state_s = state_r;
    mode_s  = mode_r;
    lfsr_s  = lfsr_r;
    acc_a_s = acc_a_r;
    acc_b_s = acc_b_r;
    cnt_s   = cnt_r;
    wrap_s  = wrap_r;
    idx_s   = idx_r;
    a_s     = a_r;
    b_s     = b_r;
    valid_s = valid_r;
    busy_s  = busy_r;
    done_s  = done_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_s      = ST_RUN;
          mode_s       = mode;
          lfsr_s       = SEED;
          acc_a_s      = ZERO_W;
          acc_b_s      = ZERO_W;
          cnt_s        = ZERO_W;
          wrap_s       = WR_ZERO;
          idx_s        = IDX_ZERO;
          {a_s, b_s}   = pattern(mode, SEED, ZERO_W, ZERO_W, ZERO_W, WR_ZERO);
          valid_s      = 1'b1;
          busy_s       = 1'b1;
          done_s       = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      ST_RUN: begin
        if (xfer_s) begin
          if (idx_r == LAST_IDX) begin
            state_s = ST_DONE;
            valid_s = 1'b0;
            busy_s  = 1'b0;
            done_s  = 1'b1;
          end else begin
            lfsr_s     = lfsr_adv_s;
            acc_a_s    = acc_a_adv_s;
            acc_b_s    = acc_b_adv_s;
            cnt_s      = cnt_adv_s;
            wrap_s     = wrap_adv_s;
            idx_s      = idx_r + IDX_ONE;
            {a_s, b_s} = pattern(mode_r, lfsr_adv_s, acc_a_adv_s, acc_b_adv_s,
                                 cnt_adv_s, wrap_adv_s);
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      default: begin
        state_s = ST_IDLE;
        valid_s = 1'b0;
        busy_s  = 1'b0;
        done_s  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      mode_r  <= 2'd0;
      lfsr_r  <= SEED;
      acc_a_r <= ZERO_W;
      acc_b_r <= ZERO_W;
      cnt_r   <= ZERO_W;
      wrap_r  <= WR_ZERO;
      idx_r   <= IDX_ZERO;
      a_r     <= ZERO_W;
      b_r     <= ZERO_W;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      mode_r  <= mode_s;
      lfsr_r  <= lfsr_s;
      acc_a_r <= acc_a_s;
      acc_b_r <= acc_b_s;
      cnt_r   <= cnt_s;
      wrap_r  <= wrap_s;
      idx_r   <= idx_s;
      a_r     <= a_s;
      b_r     <= b_s;
      valid_r <= valid_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign a       = a_r;
  assign b       = b_r;
  assign valid   = valid_r;
  assign pat_idx = idx_r;
  assign busy    = busy_r;
  assign done    = done_r;

endmodule

// File: tb/tb_adder_tpg_stream.sv
// Self-checking bench for adder_tpg_stream: scoreboard run, spot-check table,
// backpressure, short-run restart and asynchronous reset sequences.
module tb_adder_tpg_stream;

  logic        clk = 1'b0;
  logic        rst0, start0, ready0, valid0, busy0, done0;
  logic [1:0]  mode0;
  logic [15:0] a0, b0;
  logic [7:0]  idx0;
  logic        rst4, start4, ready4, valid4, busy4, done4;
  logic [1:0]  mode4;
  logic [15:0] a4, b4;
  logic [2:0]  idx4;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  idx;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [1:0]  m;
    int          idx;
    logic [15:0] ea;
    logic [15:0] eb;
  } vec_t;
  vec_t tbl[7];

  adder_tpg_stream u0 (
    .clk(clk), .rst(rst0), .start(start0), .mode(mode0), .a(a0), .b(b0),
    .valid(valid0), .ready(ready0), .pat_idx(idx0), .busy(busy0), .done(done0)
  );

  adder_tpg_stream #(.PATTERNS(4)) u4 (
    .clk(clk), .rst(rst4), .start(start4), .mode(mode4), .a(a4), .b(b4),
    .valid(valid4), .ready(ready4), .pat_idx(idx4), .busy(busy4), .done(done4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Golden model with direct multiplication and an iterated LFSR.
  function automatic logic [31:0] model(input logic [1:0] m, input int i);
    logic [15:0] l, pa, pb, oh;
    l = 16'h0001;
    for (int k = 0; k < i; k++) l = {l[14:0], ^(l & 16'hE010)};
    oh = 16'h0001 << (i % 16);
    case (m)
      2'd0: begin
        pa = (16'hFFFF - 16'(i * 511)) ^ l;
        pb = (16'h0001 + 16'(i * 509)) ^ l;
      end
      2'd1: begin pa = oh; pb = ~oh; end
      2'd2: begin pa = 16'(i); pb = ~pa; end
      default: begin pa = 16'hFFFF; pb = oh; end
    endcase
    return {pa, pb};
  endfunction

  task automatic reset0();
    @(negedge clk);
    rst0 = 1'b1; start0 = 1'b0; ready0 = 1'b0;
    @(negedge clk);
    rst0 = 1'b0;
  endtask

  // Pulse start; returns at the negedge after the accepting edge.
  task automatic start_run0(input logic [1:0] m);
    @(negedge clk);
    start0 = 1'b1; mode0 = m; ready0 = 1'b0;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic advance0(input int target);
    for (int c = 0; c < 64; c++) begin
      if (valid0 && idx0 == 8'(target)) break;
      ready0 = 1'b1;
      @(negedge clk);
    end
    ready0 = 1'b0;
  endtask

  // Full run against the scoreboard with random backpressure.
  task automatic run_sb(input logic [1:0] m);
    logic [31:0] e;
    exp_t x;
    int cyc;
    for (int i = 0; i < 128; i++) begin
      e = model(m, i);
      x.a = e[31:16]; x.b = e[15:0]; x.idx = 8'(i);
      sbq.push_back(x);
    end
    start_run0(m);
    chk("first_valid", {63'd0, valid0}, 64'd1);
    cyc = 0;
    while (sbq.size() > 0 && cyc < 3000) begin
      ready0 = ($urandom_range(0, 3) != 0);
      if (valid0 && ready0) begin
        x = sbq.pop_front();
        chk($sformatf("sb_m%0d_i%0d", m, x.idx), {a0, b0, idx0}, {x.a, x.b, x.idx});
      end
      @(negedge clk);
      cyc++;
    end
    ready0 = 1'b0;
    chk("sb_drained", 64'(sbq.size()), 64'd0);
    chk("sb_end_state", {valid0, busy0, done0}, {1'b0, 1'b0, 1'b1});
    sbq.delete();
  endtask

  initial begin
    logic [31:0] e;
    rst0 = 1'b1; start0 = 1'b0; mode0 = 2'd0; ready0 = 1'b1;
    rst4 = 1'b1; start4 = 1'b0; mode4 = 2'd0; ready4 = 1'b0;
    tbl[0] = '{2'd0, 0,  16'hFFFE, 16'h0000};
    tbl[1] = '{2'd0, 1,  16'hFE02, 16'h01FC};
    tbl[2] = '{2'd1, 17, 16'h0002, 16'hFFFD};
    tbl[3] = '{2'd3, 15, 16'hFFFF, 16'h8000};
    tbl[4] = '{2'd2, 5,  16'h0005, 16'hFFFA};
    tbl[5] = '{2'd3, 16, 16'hFFFF, 16'h0001};
    tbl[6] = '{2'd1, 0,  16'h0001, 16'hFFFE};
    repeat (2) @(negedge clk);
    rst0 = 1'b0; rst4 = 1'b0;

    // Idle with ready high and no start: nothing is emitted.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("idle", {a0, b0, idx0, valid0, busy0, done0}, 64'd0);
    end

    // Scoreboard runs in mode 0 and mode 3.
    run_sb(2'd0);
    run_sb(2'd3);

    // Spot-check table.
    for (int t = 0; t < 7; t++) begin
      reset0();
      start_run0(tbl[t].m);
      advance0(tbl[t].idx);
      chk($sformatf("tbl%0d", t), {a0, b0, idx0}, {tbl[t].ea, tbl[t].eb, 8'(tbl[t].idx)});
    end

    // Backpressure at pattern 5 for three cycles.
    reset0();
    start_run0(2'd1);
    advance0(5);
    e = model(2'd1, 5);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_hold", {a0, b0, idx0, valid0}, {e, 8'd5, 1'b1});
    end
    ready0 = 1'b1;
    @(negedge clk);
    e = model(2'd1, 6);
    chk("bp_next6", {a0, b0, idx0}, {e, 8'd6});
    @(negedge clk);
    ready0 = 1'b0;
    e = model(2'd1, 7);
    chk("bp_next7", {a0, b0, idx0}, {e, 8'd7});

    // PATTERNS=4, mode 2, start ignored in RUN, restart from DONE.
    @(negedge clk);
    start4 = 1'b1; mode4 = 2'd2; ready4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    chk("p4_i0", {a4, b4, idx4, valid4, busy4}, {16'h0000, 16'hFFFF, 3'd0, 1'b1, 1'b1});
    @(negedge clk);
    chk("p4_i1", {a4, b4, idx4}, {16'h0001, 16'hFFFE, 3'd1});
    start4 = 1'b1; mode4 = 2'd0;
    @(negedge clk);
    start4 = 1'b0;
    chk("p4_i2_start_ignored", {a4, b4, idx4}, {16'h0002, 16'hFFFD, 3'd2});
    @(negedge clk);
    chk("p4_i3", {a4, b4, idx4}, {16'h0003, 16'hFFFC, 3'd3});
    @(negedge clk);
    chk("p4_done", {a4, b4, valid4, busy4, done4}, {16'h0003, 16'hFFFC, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    chk("p4_done_sticky", {valid4, done4}, {1'b0, 1'b1});
    start4 = 1'b1; mode4 = 2'd2;
    @(negedge clk);
    start4 = 1'b0; ready4 = 1'b0;
    chk("p4_restart", {a4, b4, idx4, valid4, busy4, done4},
        {16'h0000, 16'hFFFF, 3'd0, 1'b1, 1'b1, 1'b0});

    // Asynchronous reset mid-cycle at pattern 3, then clean restart.
    reset0();
    start_run0(2'd0);
    advance0(3);
    e = model(2'd0, 3);
    chk("pre_rst_i3", {a0, b0, idx0}, {e, 8'd3});
    #2 rst0 = 1'b1;
    #1 chk("async_rst", {a0, b0, idx0, valid0, busy0, done0}, 64'd0);
    @(negedge clk);
    rst0 = 1'b0;
    start_run0(2'd0);
    chk("post_rst_i0", {a0, b0, idx0, valid0}, {16'hFFFE, 16'h0000, 8'd0, 1'b1});
    advance0(1);
    chk("post_rst_i1", {a0, b0, idx0}, {16'hFE02, 16'h01FC, 8'd1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
